// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues word-wide requests over a busywait handshake,
// steers store lanes and extends load results, stalling the pipeline while an access is open.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IN_ADDR,
    input  logic [31:0] IN_DATA2,
    input  logic [3:0]  IN_MEM_READ,
    input  logic [2:0]  IN_MEM_WRITE,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic        MEM_READ_REQ,
    output logic        MEM_WRITE_REQ,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    output logic [31:0] OUT_LOAD_DATA,
    output logic        BUSY_WAIT,
    output logic        OUT_MISALIGNED,
    output logic        OUT_TIMEOUT
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e state_q, state_d;

    logic            rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
    logic [3:0]      be_q, be_d;
    logic            mis_q, mis_d, to_q, to_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

    logic        ld_legal, is_load, is_store, op_valid, op_misaligned, timeout_hit;
    logic [1:0]  op_size;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_legal = 1'b0;
        case (IN_MEM_READ[2:0])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
            default: ld_legal = 1'b0;
        endcase
    end

    // A set load enable always wins, even when its funct3 is illegal and the op becomes a no-op.
    assign is_load  = IN_MEM_READ[3] & ld_legal;
    assign is_store = ~IN_MEM_READ[3] & IN_MEM_WRITE[2] & (IN_MEM_WRITE[1:0] != 2'b11);
    assign op_valid = is_load | is_store;
    assign op_size  = is_load ? IN_MEM_READ[1:0] : IN_MEM_WRITE[1:0];
    assign op_misaligned = ((op_size == 2'b01) & IN_ADDR[0]) |
                           ((op_size == 2'b10) & (IN_ADDR[1:0] != 2'b00));

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = '0;
        if (is_store) begin
            case (IN_MEM_WRITE[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << IN_ADDR[1:0];
                    lane_wdata = {4{IN_DATA2[7:0]}};
                end
                2'b01: begin
                    lane_be    = IN_ADDR[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{IN_DATA2[15:0]}};
                end
                default: lane_wdata = IN_DATA2;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   ld_byte = MEM_READDATA[7:0];
            2'b01:   ld_byte = MEM_READDATA[15:8];
            2'b10:   ld_byte = MEM_READDATA[23:16];
            default: ld_byte = MEM_READDATA[31:24];
        endcase
        ld_half = off_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = MEM_READDATA;
        endcase
    end

    assign cnt_inc     = cnt_q + CntW'(1);
    assign timeout_hit = MEM_BUSYWAIT & (cnt_inc == TimeoutCnt);

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (op_valid) state_d = op_misaligned ? StDone : StAccess;
            StAccess: if (!MEM_BUSYWAIT || timeout_hit) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY_WAIT = 1'b0;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        load_d    = load_q;
        mis_d     = mis_q;
        to_d      = to_q;
        f3_d      = f3_q;
        off_d     = off_q;
        cnt_d     = '0;
        unique case (state_q)
            StIdle: begin
                BUSY_WAIT = op_valid;
                if (op_valid && op_misaligned) begin
                    mis_d  = 1'b1;
                    to_d   = 1'b0;
                    load_d = '0;
                end else if (op_valid) begin
                    rd_req_d = is_load;
                    wr_req_d = is_store;
                    addr_d   = {IN_ADDR[31:2], 2'b00};
                    be_d     = lane_be;
                    wdata_d  = lane_wdata;
                    mis_d    = 1'b0;
                    to_d     = 1'b0;
                    f3_d     = IN_MEM_READ[2:0];
                    off_d    = IN_ADDR[1:0];
                end
            end
            StAccess: begin
                BUSY_WAIT = 1'b1;
                cnt_d     = cnt_inc;
                // Completion is checked first so a same-cycle finish never reports a timeout.
                if (!MEM_BUSYWAIT) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    if (rd_req_q) load_d = load_ext;
                end else if (timeout_hit) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    to_d     = 1'b1;
                    load_d   = '0;
                end
            end
            default: BUSY_WAIT = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            load_q   <= '0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            load_q   <= load_d;
            mis_q    <= mis_d;
            to_q     <= to_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
        end
    end

    assign MEM_READ_REQ   = rd_req_q;
    assign MEM_WRITE_REQ  = wr_req_q;
    assign MEM_ADDR       = addr_q;
    assign MEM_WRITEDATA  = wdata_q;
    assign MEM_BYTE_EN    = be_q;
    assign OUT_LOAD_DATA  = load_q;
    assign OUT_MISALIGNED = mis_q;
    assign OUT_TIMEOUT    = to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a behavioural memory with programmable wait states
// and a reference model that predicts stall length, request contents and load results.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IN_ADDR, IN_DATA2, MEM_READDATA;
    logic [3:0]  IN_MEM_READ;
    logic [2:0]  IN_MEM_WRITE;
    logic        MEM_BUSYWAIT;
    logic        MEM_READ_REQ, MEM_WRITE_REQ, BUSY_WAIT, OUT_MISALIGNED, OUT_TIMEOUT;
    logic [31:0] MEM_ADDR, MEM_WRITEDATA, OUT_LOAD_DATA;
    logic [3:0]  MEM_BYTE_EN;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IN_ADDR        (IN_ADDR),
        .IN_DATA2       (IN_DATA2),
        .IN_MEM_READ    (IN_MEM_READ),
        .IN_MEM_WRITE   (IN_MEM_WRITE),
        .MEM_READDATA   (MEM_READDATA),
        .MEM_BUSYWAIT   (MEM_BUSYWAIT),
        .MEM_READ_REQ   (MEM_READ_REQ),
        .MEM_WRITE_REQ  (MEM_WRITE_REQ),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WRITEDATA  (MEM_WRITEDATA),
        .MEM_BYTE_EN    (MEM_BYTE_EN),
        .OUT_LOAD_DATA  (OUT_LOAD_DATA),
        .BUSY_WAIT      (BUSY_WAIT),
        .OUT_MISALIGNED (OUT_MISALIGNED),
        .OUT_TIMEOUT    (OUT_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Memory holds busywait high for the first wait_n cycles of each request.
    int wait_n = 0;
    int req_cycles = 0;
    always @(posedge CLK) req_cycles <= (MEM_READ_REQ || MEM_WRITE_REQ) ? req_cycles + 1 : 0;
    assign MEM_BUSYWAIT = (MEM_READ_REQ || MEM_WRITE_REQ) && (req_cycles < wait_n);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Request-run monitor: counts request starts and the low gap before the latest one.
    int  req_starts = 0, low_run = 0, last_gap = -1;
    bit  seen_req = 0, req_prev = 0, rq;
    initial forever begin
        @(negedge CLK);
        rq = MEM_READ_REQ || MEM_WRITE_REQ;
        if (rq && !req_prev) begin
            if (seen_req) last_gap = low_run;
            seen_req = 1;
            req_starts++;
        end
        low_run  = rq ? 0 : low_run + 1;
        req_prev = rq;
    end

    typedef struct {
        int          stall;
        int          acc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] load;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_load = '0;
    logic        m_mis = 1'b0, m_to = 1'b0;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] b,
                                           input logic [31:0] w);
        logic [7:0]  by;
        logic [15:0] hw;
        case (b)
            2'd0:    by = w[7:0];
            2'd1:    by = w[15:8];
            2'd2:    by = w[23:16];
            default: by = w[31:24];
        endcase
        hw = b[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'h0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'h0, hw};
            default: return w;
        endcase
    endfunction

    function automatic exp_t predict(input logic [3:0] rd, input logic [2:0] wr,
                                     input logic [31:0] a, input logic [31:0] d,
                                     input logic [31:0] rdata, input int wn);
        exp_t e;
        logic is_ld, is_st, mis;
        logic [1:0] sz;
        e = '{default: 0};
        is_ld = rd[3] && (rd[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_st = !rd[3] && wr[2] && (wr[1:0] != 2'b11);
        sz    = is_ld ? rd[1:0] : wr[1:0];
        mis   = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (is_ld || is_st) begin
            if (mis) begin
                e.stall = 1;
                m_mis = 1'b1; m_to = 1'b0; m_load = '0;
            end else begin
                e.rd   = is_ld;
                e.wr   = is_st;
                e.addr = {a[31:2], 2'b00};
                e.be   = 4'hF;
                if (is_st) begin
                    e.chk_wdata = 1'b1;
                    case (sz)
                        2'b00: begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{d[7:0]}}; end
                        2'b01: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{d[15:0]}}; end
                        default: e.wdata = d;
                    endcase
                end
                m_mis = 1'b0;
                if (wn >= TO) begin
                    e.acc = TO; m_to = 1'b1; m_load = '0;
                end else begin
                    e.acc = wn + 1; m_to = 1'b0;
                    if (is_ld) m_load = extend(rd[2:0], a[1:0], rdata);
                end
                e.stall = 1 + e.acc;
            end
        end
        e.load = m_load;
        e.mis  = m_mis;
        e.to   = m_to;
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input int wn);
        exp_t e;
        int stall = 0, acc = 0;
        bit done = 0, unstable = 0;
        logic        c_rd = 0, c_wr = 0;
        logic [31:0] c_addr = '0, c_wd = '0;
        logic [3:0]  c_be = '0;
        @(posedge CLK); #1;
        IN_MEM_READ = rd; IN_MEM_WRITE = wr; IN_ADDR = a; IN_DATA2 = d;
        MEM_READDATA = rdata; wait_n = wn;
        sb_q.push_back(predict(rd, wr, a, d, rdata, wn));
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (!BUSY_WAIT) done = 1;
            else begin
                stall++;
                if (MEM_READ_REQ || MEM_WRITE_REQ) begin
                    if (acc == 0) begin
                        c_rd = MEM_READ_REQ; c_wr = MEM_WRITE_REQ; c_addr = MEM_ADDR;
                        c_be = MEM_BYTE_EN; c_wd = MEM_WRITEDATA;
                    end else if (c_rd !== MEM_READ_REQ || c_wr !== MEM_WRITE_REQ ||
                                 c_addr !== MEM_ADDR || c_be !== MEM_BYTE_EN ||
                                 c_wd !== MEM_WRITEDATA) unstable = 1;
                    acc++;
                end
            end
        end
        e = sb_q.pop_front();
        check({tag, "_released"}, 32'(done), 32'd1);
        check({tag, "_stall"}, stall, e.stall);
        check({tag, "_req_cycles"}, acc, e.acc);
        if (e.acc > 0) begin
            check({tag, "_rd_req"}, 32'(c_rd), 32'(e.rd));
            check({tag, "_wr_req"}, 32'(c_wr), 32'(e.wr));
            check({tag, "_addr"}, c_addr, e.addr);
            check({tag, "_byte_en"}, 32'(c_be), 32'(e.be));
            check({tag, "_req_stable"}, 32'(unstable), 32'd0);
        end
        if (e.chk_wdata) check({tag, "_wdata"}, c_wd, e.wdata);
        check({tag, "_reqs_low"}, 32'({MEM_READ_REQ, MEM_WRITE_REQ}), 32'd0);
        check({tag, "_load"}, OUT_LOAD_DATA, e.load);
        check({tag, "_misaligned"}, 32'(OUT_MISALIGNED), 32'(e.mis));
        check({tag, "_timeout"}, 32'(OUT_TIMEOUT), 32'(e.to));
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        IN_MEM_READ = '0; IN_MEM_WRITE = '0; IN_ADDR = '0; IN_DATA2 = '0; wait_n = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rd_req"}, 32'(MEM_READ_REQ), 32'd0);
        check({tag, "_wr_req"}, 32'(MEM_WRITE_REQ), 32'd0);
        check({tag, "_busy"}, 32'(BUSY_WAIT), 32'd0);
        check({tag, "_addr"}, MEM_ADDR, 32'd0);
        check({tag, "_byte_en"}, 32'(MEM_BYTE_EN), 32'd0);
        check({tag, "_load"}, OUT_LOAD_DATA, 32'd0);
        check({tag, "_flags"}, 32'({OUT_MISALIGNED, OUT_TIMEOUT}), 32'd0);
    endtask

    int  starts0;
    bit  got_req;

    initial begin
        RESET = 1'b1;
        IN_MEM_READ = '0; IN_MEM_WRITE = '0; IN_ADDR = '0; IN_DATA2 = '0; MEM_READDATA = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_cleared("por");
        check("por_wdata", MEM_WRITEDATA, 32'd0);

        run_op("lb",  4'b1000, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        run_op("lbu", 4'b1100, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0);
        run_op("lh",  4'b1001, 3'b000, 32'h1002, 32'h0, 32'h80FF_1234, 1);
        run_op("lhu", 4'b1101, 3'b000, 32'h1000, 32'h0, 32'h80FF_9234, 0);
        run_op("sh",  4'b0000, 3'b101, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3);
        run_op("sb",  4'b0000, 3'b100, 32'h2001, 32'h1234_56AB, 32'h0, 0);
        run_op("lw_mis", 4'b1010, 3'b000, 32'h3001, 32'h0, 32'h1111_1111, 0);
        run_op("sh_mis", 4'b0000, 3'b101, 32'h3003, 32'h5555, 32'h0, 0);
        run_op("lw_to", 4'b1010, 3'b000, 32'h3000, 32'h0, 32'h2222_2222, 100);
        run_op("lw_edge", 4'b1010, 3'b000, 32'h3004, 32'h0, 32'hCAFE_F00D, TO - 1);
        run_op("illegal", 4'b1011, 3'b110, 32'h3008, 32'h0, 32'h3333_3333, 0);
        idle();

        seen_req = 0;
        starts0  = req_starts;
        run_op("b2b_lw", 4'b1010, 3'b000, 32'h4000, 32'h0, 32'h1234_5678, 0);
        run_op("b2b_sw", 4'b0000, 3'b110, 32'h4004, 32'h1122_3344, 32'h0, 0);
        check("b2b_starts", req_starts - starts0, 32'd2);
        check("b2b_gap", last_gap, 32'd2);
        run_op("rd_wr", 4'b1100, 3'b100, 32'h4006, 32'h9999_9999, 32'hA5B6_C7D8, 0);
        idle();

        // Reset arrives while a request is outstanding on a stuck memory.
        @(posedge CLK); #1;
        IN_MEM_READ = 4'b1010; IN_ADDR = 32'h5000; MEM_READDATA = 32'h7777_7777; wait_n = 100;
        got_req = 0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge CLK);
            got_req = MEM_READ_REQ;
        end
        check("rst_req_seen", 32'(got_req), 32'd1);
        RESET = 1'b1;
        IN_MEM_READ = '0; IN_ADDR = '0;
        @(negedge CLK);
        check_cleared("rst_edge1");
        @(negedge CLK);
        RESET = 1'b0;
        wait_n = 0;
        m_load = '0; m_mis = 1'b0; m_to = 1'b0;
        @(negedge CLK);
        check_cleared("rst_after");

        run_op("post_rst", 4'b1100, 3'b000, 32'h6002, 32'h0, 32'h00C3_0000, 0);
        idle();
        repeat (2) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
